// File: rtl/clk_ctrl_pkg.sv
// ============================================================================
// Module : clk_ctrl_pkg
// Brief  : Shared state encodings and defaults for the step clock controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_ctrl_pkg;

  localparam int c_state_w = 2;

  typedef enum logic [c_state_w-1:0] {
    S_STEP  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int c_default_debounce_cycles = 4;
  localparam int c_default_run_div         = 4;

endpackage

`default_nettype wire

// File: rtl/push_debounce.sv
// ============================================================================
// Module : push_debounce
// Brief  : 2-FF synchroniser, debounce filter and registered rising-edge press.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module push_debounce
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic press
);

  localparam int              c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               level_q, level_d;
  logic               level_prev_q, level_prev_d;
  logic               press_q, press_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  // The counter tracks consecutive samples that disagree with the accepted level.
  always_comb begin
    sync1_d      = push;
    sync2_d      = sync1_q;
    level_d      = level_q;
    cnt_d        = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == c_cnt_last) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    level_prev_d = level_q;
    press_d      = level_q & ~level_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/step_clock_ctrl.sv
// ============================================================================
// Module : step_clock_ctrl
// Brief  : Run/step sequencer producing a one-cycle SIG clock-enable pulse.
//          Optional burst-per-press mode enabled by macro STEP_BURST_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_clock_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
  parameter int RUN_DIV         = c_default_run_div,
  parameter int CNT_W           = 8
`ifdef STEP_BURST_EN
  ,
  parameter int BURST_LEN       = 3
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             mode,
  input  logic             overflow,
  output logic             sig,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int                 c_div_w    = $clog2(RUN_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(RUN_DIV - 1);

  logic press;

  state_t             state_q, state_d;
  logic [c_div_w-1:0] div_q, div_d;
  logic               sig_q, sig_d;
  logic               running_q, running_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;

`ifdef STEP_BURST_EN
  localparam int c_burst_w = $clog2(BURST_LEN + 1);
  logic [c_burst_w-1:0] burst_q, burst_d;
`endif

  push_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_push_debounce (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .press (press)
  );

  // Overflow outranks every other event, so it is decoded before the state case.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sig_d   = 1'b0;
`ifdef STEP_BURST_EN
    burst_d = burst_q;
`endif
    if (overflow) begin
      state_d = S_HALT;
      div_d   = '0;
    end else begin
      case (state_q)
        S_STEP: begin
          if (mode) begin
            state_d = S_RUN;
            div_d   = '0;
          end else if (press) begin
            sig_d = 1'b1;
`ifdef STEP_BURST_EN
            if (BURST_LEN > 1) begin
              state_d = S_BURST;
              div_d   = '0;
              burst_d = c_burst_w'(BURST_LEN - 1);
            end
`endif
          end
        end
        S_RUN: begin
          if (!mode) begin
            state_d = S_STEP;
            div_d   = '0;
          end else if (div_q == c_div_last) begin
            sig_d = 1'b1;
            div_d = '0;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
`ifdef STEP_BURST_EN
        S_BURST: begin
          if (div_q == c_div_last) begin
            sig_d   = 1'b1;
            div_d   = '0;
            burst_d = burst_q - 1'b1;
            if (burst_q == c_burst_w'(1)) begin
              state_d = S_STEP;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
`endif
        S_HALT: begin
          if (press) begin
            state_d = mode ? S_RUN : S_STEP;
            div_d   = '0;
          end
        end
        default: begin
          state_d = S_STEP;
          div_d   = '0;
        end
      endcase
    end

    running_d  = (state_d == S_RUN) || (state_d == S_BURST);
    halted_d   = (state_d == S_HALT);
    step_cnt_d = step_cnt_q + {{(CNT_W-1){1'b0}}, sig_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_STEP;
      div_q      <= '0;
      sig_q      <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      step_cnt_q <= '0;
`ifdef STEP_BURST_EN
      burst_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sig_q      <= sig_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
      step_cnt_q <= step_cnt_d;
`ifdef STEP_BURST_EN
      burst_q    <= burst_d;
`endif
    end
  end

  assign sig      = sig_q;
  assign running  = running_q;
  assign halted   = halted_q;
  assign step_cnt = step_cnt_q;

endmodule

`default_nettype wire
